rf_writeback: RTL and testbench
===============================

# rf_writeback

Write-side front end for the 32 x 32-bit register file. Merges single-cycle ALU results and variable-latency memory (load) returns onto the register file's single write port (`rd_addr`/`rd_data`/`rd_wen`). It buffers load returns in a small FIFO and keeps a per-register pending-write scoreboard for decode-stage hazard checks. It sits between the execute/memory stages and the register file write port.

## Interface
Parameters:
- `DEPTH`, default 4: load-return FIFO entries; power of two, at least 2.

Ports:
- `i_clk`, input, 1: clock.
- `i_rst`, input, 1: reset. Synchronous, active-high.
- `i_alu_valid`, input, 1: ALU result valid this cycle. Always accepted; there is no ready.
- `i_alu_rd_addr`, input, 5: ALU destination register.
- `i_alu_rd_data`, input, 32: ALU result.
- `i_mem_valid`, input, 1: load return valid.
- `o_mem_ready`, output, 1: FIFO can accept a load return.
- `i_mem_rd_addr`, input, 5: load destination register.
- `i_mem_rd_data`, input, 32: load data.
- `i_issue_valid`, input, 1: a load has been issued; mark its destination pending.
- `i_issue_rd_addr`, input, 5: destination of the issued load.
- `o_rd_wen`, output, 1: register file write enable.
- `o_rd_addr`, output, 5: register file write address.
- `o_rd_data`, output, 32: register file write data.
- `o_pending`, output, 32: bit n set means a load write to xn is outstanding.

## Operation
- A load return is accepted when `i_mem_valid && o_mem_ready`. Accepted returns are pushed into the FIFO.
- `o_mem_ready` = FIFO not full. It is not asserted on a full FIFO even when a pop happens in the same cycle.
- Write arbitration, evaluated each cycle, with ALU first:
  - if `i_alu_valid`, the ALU write is selected;
  - otherwise, if the FIFO is not empty, the FIFO head is popped and selected;
  - otherwise nothing is selected.
- The selected write is registered into `o_rd_*`.
- Writes to x0:
  - `o_rd_wen` is never asserted with `o_rd_addr == 0`.
  - An ALU write to x0 is discarded.
  - A load return to x0 is accepted (the handshake completes) but is not pushed into the FIFO.
- Scoreboard:
  - `i_issue_valid` sets `o_pending[i_issue_rd_addr]`. Issue to x0 is ignored.
  - A bit is cleared in the cycle its load write is driven on `o_rd_*` (registered `o_rd_wen` from the FIFO path).
  - ALU writes never clear a bit.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - `o_pending[0]` is always 0.
- Ordering: load returns commit in arrival order. There is no ordering guarantee between ALU and load writes.

## Timing
- Reset values:
  - `o_rd_wen`=0, `o_rd_addr`=0, `o_rd_data`=0;
  - `o_pending`=0;
  - FIFO empty, so `o_mem_ready`=1 from the first cycle after reset.
- ALU latency: `i_alu_valid` in cycle N gives `o_rd_wen` in cycle N+1.
- Load latency when there is no contention: accept in cycle N, FIFO head in cycle N+1, `o_rd_wen` in cycle N+2. See Configuration for the bypass variant.
- Under sustained ALU traffic, FIFO entries stall indefinitely. `o_mem_ready` then drops after DEPTH accepts.
- A scoreboard bit clears at the edge ending the cycle in which the load is on `o_rd_*`. It reads 0 from the next cycle.
- Reset asserted mid-operation: at that edge the FIFO is flushed (buffered load data is lost), the scoreboard is cleared and `o_rd_wen` goes to 0.
- FIFO pointers wrap modulo DEPTH. The full/empty distinction uses an extra pointer bit.

## Configuration
- `RF_WB_BYPASS_EN`
  - Defined: a load return accepted in cycle N, while the FIFO is empty and `i_alu_valid` is 0, skips the FIFO and drives `o_rd_*` in cycle N+1.
  - Undefined: every load passes through the FIFO, with the 2-cycle minimum latency.
  - Arbitration priority and ordering are identical in both builds.

## Structure
- Shared package `rf_pkg`: `XLEN`=32, `REG_ADDR_W`=5, `NUM_REGS`=32, and a packed `rf_wr_t` type {addr, data}.
- Sub-module `rf_wb_fifo`: parameterised synchronous FIFO of `rf_wr_t` with push/pop/full/empty. The arbiter, output register and scoreboard live in the top module.

## Test plan
- Reset: assert `i_rst` for 2 cycles -> `o_rd_wen`=0, `o_pending`=0, `o_mem_ready`=1.
- ALU write x5=0xDEADBEEF in cycle N -> `o_rd_wen`=1, addr=5, data=0xDEADBEEF in cycle N+1. ALU write to x0 -> `o_rd_wen` stays 0.
- Issue load x7, then return x7=0x1234 with no ALU traffic -> `o_pending[7]`=1 until the write appears on `o_rd_*`; it is 0 the next cycle. Write appears at N+2 (N+1 with `RF_WB_BYPASS_EN`).
- Drive ALU valid every cycle plus 5 load returns with DEPTH=4 -> `o_mem_ready` drops after the 4th accept. When ALU traffic stops, the 4 loads commit in arrival order.
- In the same cycle, issue x9 while a FIFO write to x9 commits -> `o_pending[9]` remains 1.
- Assert reset with 3 FIFO entries buffered -> no further writes appear, `o_pending`=0, `o_mem_ready`=1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file types and widths for the writeback front end.
package rf_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } rf_wr_t;

   // One-hot register mask for scoreboard set/clear.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
      reg_onehot = NUM_REGS'(1) << a;
   endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of register writes; extra pointer bit separates full from empty.
module rf_wb_fifo
   import rf_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  rf_wr_t push_data,
   input  logic   pop,
   output rf_wr_t head,
   output logic   full,
   output logic   empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rf_wr_t          mem [DEPTH];
   logic   [AW:0]   wr_ptr;
   logic   [AW:0]   rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage carries no reset; contents are only read behind a valid pointer.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-port arbiter (ALU first, then buffered loads) with pending-load scoreboard.
// Optional feature: define RF_WB_BYPASS_EN to let a load skip an empty FIFO when the ALU is idle.
module rf_writeback
   import rf_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_alu_valid,
   input  logic [REG_ADDR_W-1:0] i_alu_rd_addr,
   input  logic [XLEN-1:0]       i_alu_rd_data,
   input  logic                  i_mem_valid,
   output logic                  o_mem_ready,
   input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
   input  logic [XLEN-1:0]       i_mem_rd_data,
   input  logic                  i_issue_valid,
   input  logic [REG_ADDR_W-1:0] i_issue_rd_addr,
   output logic                  o_rd_wen,
   output logic [REG_ADDR_W-1:0] o_rd_addr,
   output logic [XLEN-1:0]       o_rd_data,
   output logic [NUM_REGS-1:0]   o_pending
);

   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;
   logic                fifo_pop;
   rf_wr_t              fifo_head;
   rf_wr_t              mem_wr;
   rf_wr_t              alu_wr;
   logic                mem_accept;
   logic                bypass_take;

   logic                sel_wen;
   logic                sel_load;
   rf_wr_t              sel_wr;
   logic                rd_load;

   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] pending_d;

   assign mem_wr      = '{addr: i_mem_rd_addr, data: i_mem_rd_data};
   assign alu_wr      = '{addr: i_alu_rd_addr, data: i_alu_rd_data};
   assign o_mem_ready = !fifo_full;
   assign mem_accept  = i_mem_valid && !fifo_full;

`ifdef RF_WB_BYPASS_EN
   assign bypass_take = mem_accept && fifo_empty && !i_alu_valid;
`else
   assign bypass_take = 1'b0;
`endif

   // x0 returns complete the handshake but are never buffered.
   assign fifo_push = mem_accept && (i_mem_rd_addr != '0) && !bypass_take;
   assign fifo_pop  = !i_alu_valid && !fifo_empty;

   rf_wb_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .push      (fifo_push),
      .push_data (mem_wr),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Write-port arbitration: ALU, then FIFO head, then bypassed load.
   always_comb begin
      sel_wen  = 1'b0;
      sel_load = 1'b0;
      sel_wr   = fifo_head;
      if (i_alu_valid) begin
         sel_wr  = alu_wr;
         sel_wen = (i_alu_rd_addr != '0);
      end else if (!fifo_empty) begin
         sel_wen  = 1'b1;
         sel_load = 1'b1;
      end else if (bypass_take) begin
         sel_wr   = mem_wr;
         sel_wen  = (i_mem_rd_addr != '0);
         sel_load = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rd_wen  <= 1'b0;
         o_rd_addr <= '0;
         o_rd_data <= '0;
         rd_load   <= 1'b0;
      end else begin
         o_rd_wen <= sel_wen;
         rd_load  <= sel_wen && sel_load;
         if (sel_wen) begin
            o_rd_addr <= sel_wr.addr;
            o_rd_data <= sel_wr.data;
         end
      end
   end

   // Scoreboard: a load write on the port clears its bit; a same-cycle issue re-sets it.
   always_comb begin
      clr_mask  = '0;
      set_mask  = '0;
      if (o_rd_wen && rd_load)
         clr_mask = reg_onehot(o_rd_addr);
      if (i_issue_valid && (i_issue_rd_addr != '0))
         set_mask = reg_onehot(i_issue_rd_addr);
      pending_d = ((o_pending & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_pending <= '0;
      else
         o_pending <= pending_d;
   end

endmodule

// File: tb/tb_rf_writeback.sv
// Directed and random checks of rf_writeback against a queue-based reference model.
module tb_rf_writeback;
   import rf_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_alu_valid;
   logic [4:0]  i_alu_rd_addr;
   logic [31:0] i_alu_rd_data;
   logic        i_mem_valid;
   logic        o_mem_ready;
   logic [4:0]  i_mem_rd_addr;
   logic [31:0] i_mem_rd_data;
   logic        i_issue_valid;
   logic [4:0]  i_issue_rd_addr;
   logic        o_rd_wen;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;
   logic [31:0] o_pending;

   int errors = 0;
   int checks = 0;

   // Reference model state
   rf_wr_t      q[$];
   logic [31:0] m_pend;
   logic        m_wen;
   logic        m_load;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   bit          model_valid = 0;

   always #5 clk = ~clk;

   rf_writeback #(.DEPTH(DEPTH)) dut (
      .i_clk           (clk),
      .i_rst           (i_rst),
      .i_alu_valid     (i_alu_valid),
      .i_alu_rd_addr   (i_alu_rd_addr),
      .i_alu_rd_data   (i_alu_rd_data),
      .i_mem_valid     (i_mem_valid),
      .o_mem_ready     (o_mem_ready),
      .i_mem_rd_addr   (i_mem_rd_addr),
      .i_mem_rd_data   (i_mem_rd_data),
      .i_issue_valid   (i_issue_valid),
      .i_issue_rd_addr (i_issue_rd_addr),
      .o_rd_wen        (o_rd_wen),
      .o_rd_addr       (o_rd_addr),
      .o_rd_data       (o_rd_data),
      .o_pending       (o_pending)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      i_rst         = 1'b0;
      i_alu_valid   = 1'b0;
      i_alu_rd_addr = '0;
      i_alu_rd_data = '0;
      i_mem_valid   = 1'b0;
      i_mem_rd_addr = '0;
      i_mem_rd_data = '0;
      i_issue_valid = 1'b0;
      i_issue_rd_addr = '0;
   endtask

   // Advance one clock: update the model from the driven inputs, then compare.
   task automatic step();
      bit     acc;
      bit     byp;
      rf_wr_t e;
      if (model_valid)
         check("mem_ready", 32'(o_mem_ready), 32'(q.size() < DEPTH));
      if (i_rst) begin
         q.delete();
         m_pend = '0;
         m_wen  = 1'b0;
         m_load = 1'b0;
         m_addr = '0;
         m_data = '0;
         model_valid = 1;
      end else begin
         acc = i_mem_valid && (q.size() < DEPTH);
         byp = 0;
         if (m_wen && m_load)
            m_pend[m_addr] = 1'b0;
         if (i_alu_valid) begin
            m_wen  = (i_alu_rd_addr != 0);
            m_load = 1'b0;
            if (m_wen) begin
               m_addr = i_alu_rd_addr;
               m_data = i_alu_rd_data;
            end
         end else if (q.size() > 0) begin
            e      = q.pop_front();
            m_wen  = 1'b1;
            m_load = 1'b1;
            m_addr = e.addr;
            m_data = e.data;
         end else begin
            m_wen  = 1'b0;
            m_load = 1'b0;
`ifdef RF_WB_BYPASS_EN
            if (acc) begin
               byp = 1;
               if (i_mem_rd_addr != 0) begin
                  m_wen  = 1'b1;
                  m_load = 1'b1;
                  m_addr = i_mem_rd_addr;
                  m_data = i_mem_rd_data;
               end
            end
`endif
         end
         if (acc && !byp && i_mem_rd_addr != 0)
            q.push_back('{addr: i_mem_rd_addr, data: i_mem_rd_data});
         if (i_issue_valid && i_issue_rd_addr != 0)
            m_pend[i_issue_rd_addr] = 1'b1;
      end
      @(posedge clk);
      #1;
      check("rd_wen", 32'(o_rd_wen), 32'(m_wen));
      check("pending", o_pending, m_pend);
      if (m_wen) begin
         check("rd_addr", 32'(o_rd_addr), 32'(m_addr));
         check("rd_data", o_rd_data, m_data);
      end
   endtask

   initial begin
      bit hit;
      idle();
      @(posedge clk);
      #1;

      // Reset for two cycles
      i_rst = 1'b1;
      step();
      step();
      idle();
      check("reset_addr", 32'(o_rd_addr), 32'h0);
      check("reset_data", o_rd_data, 32'h0);
      check("reset_ready", 32'(o_mem_ready), 32'h1);

      // ALU writes, including one to x0
      i_alu_valid = 1'b1; i_alu_rd_addr = 5'd5; i_alu_rd_data = 32'hDEADBEEF;
      step();
      check("alu_x5_data", o_rd_data, 32'hDEADBEEF);
      i_alu_rd_addr = 5'd0; i_alu_rd_data = 32'h1111_2222;
      step();
      check("alu_x0_wen", 32'(o_rd_wen), 32'h0);
      idle();

      // Issue x7, return x7 with no ALU traffic
      i_issue_valid = 1'b1; i_issue_rd_addr = 5'd7;
      step();
      idle();
      i_mem_valid = 1'b1; i_mem_rd_addr = 5'd7; i_mem_rd_data = 32'h1234;
      step();
      idle();
      for (int k = 0; k < 4; k++) step();
      check("x7_cleared", 32'(o_pending[7]), 32'h0);

      // Sustained ALU traffic with five load returns
      for (int k = 0; k < 8; k++) begin
         i_alu_valid   = 1'b1;
         i_alu_rd_addr = 5'($urandom_range(31, 1));
         i_alu_rd_data = $urandom;
         i_mem_valid   = (k < 5);
         i_mem_rd_addr = 5'(10 + k);
         i_mem_rd_data = 32'hA000_0000 + 32'(k);
         step();
      end
      check("ready_low_full", 32'(o_mem_ready), 32'h0);
      idle();
      for (int k = 0; k < 6; k++) step();

      // Issue to x9 in the cycle its FIFO write is on the port
      i_issue_valid = 1'b1; i_issue_rd_addr = 5'd9;
      step();
      idle();
      i_mem_valid = 1'b1; i_mem_rd_addr = 5'd9; i_mem_rd_data = 32'h9999;
      step();
      idle();
      hit = 0;
      for (int k = 0; k < 6; k++) begin
         if (!hit && o_rd_wen === 1'b1 && o_rd_addr === 5'd9) begin
            hit = 1;
            i_issue_valid = 1'b1; i_issue_rd_addr = 5'd9;
            step();
            idle();
            check("x9_set_wins", 32'(o_pending[9]), 32'h1);
         end else begin
            step();
         end
      end
      check("x9_collision_seen", 32'(hit), 32'h1);

      // Reset with three entries buffered behind ALU traffic
      for (int k = 0; k < 3; k++) begin
         i_alu_valid   = 1'b1;
         i_alu_rd_addr = 5'd3;
         i_alu_rd_data = $urandom;
         i_mem_valid   = 1'b1;
         i_mem_rd_addr = 5'(20 + k);
         i_mem_rd_data = $urandom;
         i_issue_valid = 1'b1;
         i_issue_rd_addr = 5'(20 + k);
         step();
      end
      idle();
      i_rst = 1'b1;
      step();
      idle();
      check("flush_pending", o_pending, 32'h0);
      check("flush_ready", 32'(o_mem_ready), 32'h1);
      for (int k = 0; k < 4; k++) step();

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         i_rst           = ($urandom_range(99, 0) == 0);
         i_alu_valid     = ($urandom_range(2, 0) == 0);
         i_alu_rd_addr   = 5'($urandom);
         i_alu_rd_data   = $urandom;
         i_mem_valid     = $urandom_range(1, 0) == 1;
         i_mem_rd_addr   = 5'($urandom);
         i_mem_rd_data   = $urandom;
         i_issue_valid   = $urandom_range(1, 0) == 1;
         i_issue_rd_addr = 5'($urandom);
         step();
      end
      idle();
      for (int k = 0; k < 8; k++) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
